// File: rtl/m72_pkg.sv
// Shared types and constants for the M72 SDRAM arbiter.
package m72_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    PORT_SPRITE,
    PORT_BG,
    PORT_CPU
  } sdr_port_t;

  localparam logic [1:0] BURST_1 = 2'd0;
  localparam logic [1:0] BURST_2 = 2'd1;
  localparam logic [1:0] BURST_4 = 2'd3;

  function automatic logic [1:0] port_burst(input sdr_port_t p);
    case (p)
      PORT_SPRITE: return BURST_4;
      PORT_BG:     return BURST_2;
      default:     return BURST_1;
    endcase
  endfunction

endpackage

// File: rtl/sdr_arb_slot.sv
// One requester slot: pending latch, captured request fields, drop detect, rdy pulse and dout.
module sdr_arb_slot #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [23:0]   addr,
  input  logic [15:0]   din,
  input  logic [1:0]    wr_sel,
  input  logic          done,
  input  logic [DW-1:0] rdata,
  output logic          pending,
  output logic [23:0]   cap_addr,
  output logic [15:0]   cap_din,
  output logic [1:0]    cap_wr_sel,
  output logic          rdy,
  output logic [DW-1:0] dout,
  output logic          dropped
);

  logic          pending_q;
  logic [23:0]   addr_q;
  logic [15:0]   din_q;
  logic [1:0]    wr_sel_q;
  logic          rdy_q;
  logic [DW-1:0] dout_q;
  logic          accept;

  // A completion in the same cycle frees the slot, so the new request is taken.
  assign accept  = req && (!pending_q || done);
  assign dropped = req && pending_q && !done;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      wr_sel_q  <= '0;
      rdy_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      rdy_q <= done;
      if (done) begin
        dout_q <= rdata;
      end
      if (accept) begin
        pending_q <= 1'b1;
        addr_q    <= addr;
        din_q     <= din;
        wr_sel_q  <= wr_sel;
      end else if (done) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign pending    = pending_q;
  assign cap_addr   = addr_q;
  assign cap_din    = din_q;
  assign cap_wr_sel = wr_sel_q;
  assign rdy        = rdy_q;
  assign dout       = dout_q;

endmodule

// File: rtl/sdr_arbiter.sv
// Three-way SDRAM client arbiter (sprite > bg > cpu), one transaction outstanding.
// Define SDR_ARB_FAIRNESS_EN to add the CPU starvation counter.
module sdr_arbiter
  import m72_pkg::*;
#(
  parameter int unsigned CPU_STARVE_LIMIT = 4
) (
  input  logic        CLK_96M,
  input  logic        reset,
  input  logic [23:0] spr_addr,
  input  logic        spr_req,
  output logic        spr_rdy,
  output logic [63:0] spr_dout,
  input  logic [23:0] bg_addr,
  input  logic        bg_req,
  output logic        bg_rdy,
  output logic [31:0] bg_dout,
  input  logic [23:0] cpu_addr,
  input  logic        cpu_req,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_wr_sel,
  output logic        cpu_rdy,
  output logic [15:0] cpu_dout,
  output logic [23:0] sdr_addr,
  output logic [1:0]  sdr_burst,
  output logic [15:0] sdr_din,
  output logic [1:0]  sdr_wr_sel,
  output logic        sdr_req,
  input  logic        sdr_rdy,
  input  logic [63:0] sdr_dout,
  output logic        dropped_req
);

  logic        spr_pend, bg_pend, cpu_pend;
  logic [23:0] spr_cap_addr, bg_cap_addr, cpu_cap_addr;
  logic [15:0] cpu_cap_din;
  logic [1:0]  cpu_cap_wr_sel;
  logic        spr_drop, bg_drop, cpu_drop;
  logic        spr_done, bg_done, cpu_done;
  logic [15:0] spr_unused_din, bg_unused_din;
  logic [1:0]  spr_unused_wr, bg_unused_wr;

  arb_state_t  state_q, state_d;
  sdr_port_t   grant_q, grant_d, win;
  logic        load, complete, force_cpu;

  logic [23:0] issue_addr;
  logic [15:0] issue_din;
  logic [1:0]  issue_wr_sel;

  logic [23:0] sdr_addr_q;
  logic [1:0]  sdr_burst_q;
  logic [15:0] sdr_din_q;
  logic [1:0]  sdr_wr_sel_q;
  logic        sdr_req_q;
  logic        dropped_q;

  assign complete = (state_q == ARB_WAIT) && sdr_rdy;
  assign spr_done = complete && (grant_q == PORT_SPRITE);
  assign bg_done  = complete && (grant_q == PORT_BG);
  assign cpu_done = complete && (grant_q == PORT_CPU);

  sdr_arb_slot #(.DW(64)) u_spr (
    .clk        (CLK_96M),
    .reset      (reset),
    .req        (spr_req),
    .addr       (spr_addr),
    .din        (16'h0000),
    .wr_sel     (2'b00),
    .done       (spr_done),
    .rdata      (sdr_dout),
    .pending    (spr_pend),
    .cap_addr   (spr_cap_addr),
    .cap_din    (spr_unused_din),
    .cap_wr_sel (spr_unused_wr),
    .rdy        (spr_rdy),
    .dout       (spr_dout),
    .dropped    (spr_drop)
  );

  sdr_arb_slot #(.DW(32)) u_bg (
    .clk        (CLK_96M),
    .reset      (reset),
    .req        (bg_req),
    .addr       (bg_addr),
    .din        (16'h0000),
    .wr_sel     (2'b00),
    .done       (bg_done),
    .rdata      (sdr_dout[31:0]),
    .pending    (bg_pend),
    .cap_addr   (bg_cap_addr),
    .cap_din    (bg_unused_din),
    .cap_wr_sel (bg_unused_wr),
    .rdy        (bg_rdy),
    .dout       (bg_dout),
    .dropped    (bg_drop)
  );

  sdr_arb_slot #(.DW(16)) u_cpu (
    .clk        (CLK_96M),
    .reset      (reset),
    .req        (cpu_req),
    .addr       (cpu_addr),
    .din        (cpu_din),
    .wr_sel     (cpu_wr_sel),
    .done       (cpu_done),
    .rdata      (sdr_dout[15:0]),
    .pending    (cpu_pend),
    .cap_addr   (cpu_cap_addr),
    .cap_din    (cpu_cap_din),
    .cap_wr_sel (cpu_cap_wr_sel),
    .rdy        (cpu_rdy),
    .dout       (cpu_dout),
    .dropped    (cpu_drop)
  );

`ifdef SDR_ARB_FAIRNESS_EN
  localparam int unsigned StarveW = $clog2(CPU_STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(CPU_STARVE_LIMIT);

  logic [StarveW-1:0] starve_q;

  assign force_cpu = cpu_pend && (starve_q >= StarveMax);

  // Counts grants lost by a waiting CPU; saturates at the limit.
  always_ff @(posedge CLK_96M) begin
    if (reset || !cpu_pend) begin
      starve_q <= '0;
    end else if (load) begin
      if (win == PORT_CPU) begin
        starve_q <= '0;
      end else if (starve_q != StarveMax) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end
`else
  logic unused_limit;
  assign unused_limit = ^CPU_STARVE_LIMIT;
  assign force_cpu    = 1'b0;
`endif

  always_comb begin
    if (force_cpu)     win = PORT_CPU;
    else if (spr_pend) win = PORT_SPRITE;
    else if (bg_pend)  win = PORT_BG;
    else               win = PORT_CPU;
  end

  always_comb begin
    issue_addr   = cpu_cap_addr;
    issue_din    = cpu_cap_din;
    issue_wr_sel = cpu_cap_wr_sel;
    case (win)
      PORT_SPRITE: begin
        issue_addr   = spr_cap_addr;
        issue_din    = 16'h0000;
        issue_wr_sel = 2'b00;
      end
      PORT_BG: begin
        issue_addr   = bg_cap_addr;
        issue_din    = 16'h0000;
        issue_wr_sel = 2'b00;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    load    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (spr_pend || bg_pend || cpu_pend) begin
          grant_d = win;
          load    = 1'b1;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT:  if (sdr_rdy) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK_96M) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= PORT_SPRITE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Downstream fields are loaded at grant time so they stay stable through WAIT.
  always_ff @(posedge CLK_96M) begin
    if (reset) begin
      sdr_req_q    <= 1'b0;
      sdr_addr_q   <= '0;
      sdr_burst_q  <= BURST_1;
      sdr_din_q    <= '0;
      sdr_wr_sel_q <= 2'b00;
      dropped_q    <= 1'b0;
    end else begin
      sdr_req_q <= load;
      if (load) begin
        sdr_addr_q   <= issue_addr;
        sdr_burst_q  <= port_burst(win);
        sdr_din_q    <= issue_din;
        sdr_wr_sel_q <= issue_wr_sel;
      end
      dropped_q <= dropped_q | spr_drop | bg_drop | cpu_drop;
    end
  end

  assign sdr_req     = sdr_req_q;
  assign sdr_addr    = sdr_addr_q;
  assign sdr_burst   = sdr_burst_q;
  assign sdr_din     = sdr_din_q;
  assign sdr_wr_sel  = sdr_wr_sel_q;
  assign dropped_req = dropped_q;

endmodule

// File: tb/tb_sdr_arbiter.sv
// Directed vector bench for sdr_arbiter; honours SDR_ARB_FAIRNESS_EN for the starvation case.
module tb_sdr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] spr_addr, bg_addr, cpu_addr;
  logic        spr_req, bg_req, cpu_req;
  logic        spr_rdy, bg_rdy, cpu_rdy;
  logic [63:0] spr_dout;
  logic [31:0] bg_dout;
  logic [15:0] cpu_dout, cpu_din;
  logic [1:0]  cpu_wr_sel;
  logic [23:0] sdr_addr;
  logic [1:0]  sdr_burst, sdr_wr_sel;
  logic [15:0] sdr_din;
  logic        sdr_req, sdr_rdy;
  logic [63:0] sdr_dout;
  logic        dropped_req;

  always #5 clk = ~clk;

  sdr_arbiter #(.CPU_STARVE_LIMIT(4)) dut (
    .CLK_96M     (clk),
    .reset       (reset),
    .spr_addr    (spr_addr),
    .spr_req     (spr_req),
    .spr_rdy     (spr_rdy),
    .spr_dout    (spr_dout),
    .bg_addr     (bg_addr),
    .bg_req      (bg_req),
    .bg_rdy      (bg_rdy),
    .bg_dout     (bg_dout),
    .cpu_addr    (cpu_addr),
    .cpu_req     (cpu_req),
    .cpu_din     (cpu_din),
    .cpu_wr_sel  (cpu_wr_sel),
    .cpu_rdy     (cpu_rdy),
    .cpu_dout    (cpu_dout),
    .sdr_addr    (sdr_addr),
    .sdr_burst   (sdr_burst),
    .sdr_din     (sdr_din),
    .sdr_wr_sel  (sdr_wr_sel),
    .sdr_req     (sdr_req),
    .sdr_rdy     (sdr_rdy),
    .sdr_dout    (sdr_dout),
    .dropped_req (dropped_req)
  );

  typedef struct {
    int          port;      // 0 sprite, 1 bg, 2 cpu
    logic [23:0] addr;
    logic [15:0] din;
    logic [1:0]  wr_sel;
    logic [63:0] rdata;
    logic [1:0]  exp_burst;
    logic [1:0]  exp_wr_sel;
    logic [15:0] exp_din;
    logic [63:0] exp_dout;
    logic [2:0]  exp_rdy;   // {spr, bg, cpu}
  } vec_t;

  vec_t vecs[6];

  int n_cmp = 0;
  int n_bad = 0;
  int c_spr = 0, c_bg = 0, c_cpu = 0;
  logic [1:0] burst_q[$];

  always @(negedge clk) begin
    if (spr_rdy === 1'b1) c_spr++;
    if (bg_rdy === 1'b1) c_bg++;
    if (cpu_rdy === 1'b1) c_cpu++;
    if (sdr_req === 1'b1) burst_q.push_back(sdr_burst);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    c_spr = 0;
    c_bg  = 0;
    c_cpu = 0;
    burst_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] pack_q();
    logic [15:0] pk = '0;
    foreach (burst_q[i]) pk = {pk[13:0], burst_q[i]};
    return pk;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"}, {61'd0, spr_rdy, bg_rdy, cpu_rdy}, 64'd0);
    chk({tag, "_spr_dout"}, spr_dout, 64'd0);
    chk({tag, "_bg_dout"}, {32'd0, bg_dout}, 64'd0);
    chk({tag, "_cpu_dout"}, {48'd0, cpu_dout}, 64'd0);
    chk({tag, "_sdr_req"}, {63'd0, sdr_req}, 64'd0);
    chk({tag, "_sdr_fields"}, {20'd0, sdr_addr, sdr_burst, sdr_din, sdr_wr_sel}, 64'd0);
    chk({tag, "_dropped"}, {63'd0, dropped_req}, 64'd0);
  endtask

  // Waits for sdr_req, then answers one cycle into WAIT with the given data.
  task automatic serve(input logic [63:0] data);
    int n = 0;
    while (sdr_req !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    if (sdr_req !== 1'b1) begin
      chk("serve_timeout", {63'd0, sdr_req}, 64'd1);
      return;
    end
    tick();
    sdr_rdy  = 1'b1;
    sdr_dout = data;
    tick();
    sdr_rdy  = 1'b0;
    sdr_dout = '0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [63:0] got_dout;
    case (v.port)
      0: begin spr_req = 1'b1; spr_addr = v.addr; end
      1: begin bg_req = 1'b1; bg_addr = v.addr; end
      default: begin
        cpu_req = 1'b1; cpu_addr = v.addr; cpu_din = v.din; cpu_wr_sel = v.wr_sel;
      end
    endcase
    tick();
    spr_req = 1'b0; bg_req = 1'b0; cpu_req = 1'b0;
    chk($sformatf("v%0d_req_n1", i), {63'd0, sdr_req}, 64'd0);
    tick();
    chk($sformatf("v%0d_req_n2", i), {63'd0, sdr_req}, 64'd1);
    chk($sformatf("v%0d_addr", i), {40'd0, sdr_addr}, {40'd0, v.addr});
    chk($sformatf("v%0d_burst", i), {62'd0, sdr_burst}, {62'd0, v.exp_burst});
    chk($sformatf("v%0d_din", i), {48'd0, sdr_din}, {48'd0, v.exp_din});
    chk($sformatf("v%0d_wr_sel", i), {62'd0, sdr_wr_sel}, {62'd0, v.exp_wr_sel});
    tick();
    chk($sformatf("v%0d_wait_req", i), {63'd0, sdr_req}, 64'd0);
    chk($sformatf("v%0d_wait_hold", i), {20'd0, sdr_addr, sdr_burst, sdr_din, sdr_wr_sel},
        {20'd0, v.addr, v.exp_burst, v.exp_din, v.exp_wr_sel});
    tick();
    tick();
    sdr_rdy  = 1'b1;
    sdr_dout = v.rdata;
    tick();
    sdr_rdy  = 1'b0;
    sdr_dout = '0;
    case (v.port)
      0:       got_dout = spr_dout;
      1:       got_dout = {32'd0, bg_dout};
      default: got_dout = {48'd0, cpu_dout};
    endcase
    chk($sformatf("v%0d_rdy", i), {61'd0, spr_rdy, bg_rdy, cpu_rdy}, {61'd0, v.exp_rdy});
    chk($sformatf("v%0d_dout", i), got_dout, v.exp_dout);
    tick();
    chk($sformatf("v%0d_rdy_off", i), {61'd0, spr_rdy, bg_rdy, cpu_rdy}, 64'd0);
    chk($sformatf("v%0d_idle_req", i), {63'd0, sdr_req}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{2, 24'h000100, 16'h0000, 2'b00, 64'h1111_2222_3333_BEEF,
                2'd0, 2'b00, 16'h0000, 64'h0000_0000_0000_BEEF, 3'b001};
    vecs[1] = '{2, 24'h00ABCD, 16'h1234, 2'b10, 64'h9999_8888_7777_6666,
                2'd0, 2'b10, 16'h1234, 64'h0000_0000_0000_6666, 3'b001};
    vecs[2] = '{0, 24'h123456, 16'h0000, 2'b00, 64'h0123_4567_89AB_CDEF,
                2'd3, 2'b00, 16'h0000, 64'h0123_4567_89AB_CDEF, 3'b100};
    vecs[3] = '{1, 24'hFFFFFF, 16'h0000, 2'b00, 64'hDEAD_BEEF_CAFE_F00D,
                2'd1, 2'b00, 16'h0000, 64'h0000_0000_CAFE_F00D, 3'b010};
    vecs[4] = '{2, 24'h800001, 16'hA5A5, 2'b01, 64'h0000_0000_0000_0000,
                2'd0, 2'b01, 16'hA5A5, 64'h0000_0000_0000_0000, 3'b001};
    vecs[5] = '{1, 24'h000002, 16'h0000, 2'b00, 64'h5555_AAAA_1357_2468,
                2'd1, 2'b00, 16'h0000, 64'h0000_0000_1357_2468, 3'b010};

    reset = 1'b1;
    spr_addr = '0; bg_addr = '0; cpu_addr = '0;
    spr_req = 1'b0; bg_req = 1'b0; cpu_req = 1'b0;
    cpu_din = '0; cpu_wr_sel = 2'b00;
    sdr_rdy = 1'b0; sdr_dout = '0;
    do_reset();
    chk_reset_outputs("reset");

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // All three request together: strict priority order, one rdy each.
    do_reset();
    clear_mon();
    spr_req = 1'b1; spr_addr = 24'h000010;
    bg_req  = 1'b1; bg_addr  = 24'h000020;
    cpu_req = 1'b1; cpu_addr = 24'h000030; cpu_din = 16'h0; cpu_wr_sel = 2'b00;
    tick();
    spr_req = 1'b0; bg_req = 1'b0; cpu_req = 1'b0;
    serve(64'hAAAA_0000_0000_0001);
    serve(64'hBBBB_0000_0000_0002);
    serve(64'hCCCC_0000_0000_0003);
    repeat (6) tick();
    chk("order_count", 64'(burst_q.size()), 64'd3);
    chk("order_bursts", {48'd0, pack_q()}, 64'h0000_0000_0000_0034);
    chk("order_rdy_counts", {40'd0, 8'(c_spr), 8'(c_bg), 8'(c_cpu)}, 64'h0000_0000_0001_0101);
    chk("order_spr_dout", spr_dout, 64'hAAAA_0000_0000_0001);
    chk("order_bg_dout", {32'd0, bg_dout}, 64'h0000_0000_0000_0002);
    chk("order_cpu_dout", {48'd0, cpu_dout}, 64'h0000_0000_0000_0003);

    // CPU pending against continuously re-requesting sprite and bg.
    do_reset();
    clear_mon();
    spr_req = 1'b1; bg_req = 1'b1; cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    for (int k = 0; k < 5; k++) serve(64'h0000_0000_0000_0100 + 64'(k));
    spr_req = 1'b0; bg_req = 1'b0;
`ifdef SDR_ARB_FAIRNESS_EN
    for (int k = 0; k < 2; k++) serve(64'h0000_0000_0000_0200 + 64'(k));
    repeat (6) tick();
    chk("starve_count", 64'(burst_q.size()), 64'd7);
    chk("starve_bursts", {48'd0, pack_q()}, 64'h0000_0000_0000_3FCD);
`else
    for (int k = 0; k < 3; k++) serve(64'h0000_0000_0000_0200 + 64'(k));
    repeat (6) tick();
    chk("starve_count", 64'(burst_q.size()), 64'd8);
    chk("starve_bursts", {48'd0, pack_q()}, 64'h0000_0000_0000_FFF4);
`endif
    chk("starve_cpu_rdy", 64'(c_cpu), 64'd1);
    chk("starve_dropped", {63'd0, dropped_req}, 64'd1);

    // Second bg_req while pending is dropped and only one transaction issues.
    do_reset();
    clear_mon();
    chk("drop_clear", {63'd0, dropped_req}, 64'd0);
    bg_req = 1'b1; bg_addr = 24'h000444;
    tick();
    bg_addr = 24'h000555;
    tick();
    bg_req = 1'b0;
    chk("drop_flag", {63'd0, dropped_req}, 64'd1);
    serve(64'h0000_0000_0BAD_F00D);
    repeat (8) tick();
    chk("drop_txn_count", 64'(burst_q.size()), 64'd1);
    chk("drop_bg_rdy", 64'(c_bg), 64'd1);
    chk("drop_bg_dout", {32'd0, bg_dout}, 64'h0000_0000_0BAD_F00D);
    chk("drop_still_set", {63'd0, dropped_req}, 64'd1);

    // Reset during WAIT discards the result; stray sdr_rdy in IDLE is ignored.
    clear_mon();
    cpu_req = 1'b1; cpu_addr = 24'h00C0DE; cpu_din = 16'h7777; cpu_wr_sel = 2'b11;
    tick();
    cpu_req = 1'b0;
    tick();
    chk("rst_pre_req", {63'd0, sdr_req}, 64'd1);
    tick();
    reset    = 1'b1;
    sdr_rdy  = 1'b1;
    sdr_dout = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    reset = 1'b0;
    chk_reset_outputs("rst_wait");
    tick();
    tick();
    sdr_rdy  = 1'b0;
    sdr_dout = '0;
    repeat (6) tick();
    chk("rst_no_rdy", {40'd0, 8'(c_spr), 8'(c_bg), 8'(c_cpu)}, 64'd0);
    chk("rst_no_reissue", 64'(burst_q.size()), 64'd1);
    chk("rst_cpu_dout", {48'd0, cpu_dout}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdr_arbiter.md
# sdr_arbiter

Shares one SDRAM client channel among the three M72 requesters: sprite fetch, background tile fetch and CPU ROM/RAM. Each requester keeps its existing single-cycle `req` / single-cycle `rdy` handshake. The block latches each request, picks one winner at a time, issues it downstream with the correct burst length, and routes the returned data back. It sits between `m72` and the SDRAM controller in the `CLK_96M` domain.

## Interface
- `CPU_STARVE_LIMIT`, default 4: number of consecutive grants the CPU may lose while pending before it is forced to win (fairness build only).
- `CLK_96M` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `spr_addr` in 24 [24:1]; `spr_req` in 1; `spr_rdy` out 1; `spr_dout` out 64: sprite port, 4-word burst.
- `bg_addr` in 24; `bg_req` in 1; `bg_rdy` out 1; `bg_dout` out 32: background port, 2-word burst.
- `cpu_addr` in 24; `cpu_req` in 1; `cpu_din` in 16; `cpu_wr_sel` in 2; `cpu_rdy` out 1; `cpu_dout` out 16: CPU port, 1 word; `cpu_wr_sel`=00 means read.
- `sdr_addr` out 24; `sdr_burst` out 2 (0=1 word, 1=2 words, 3=4 words); `sdr_din` out 16; `sdr_wr_sel` out 2; `sdr_req` out 1; `sdr_rdy` in 1; `sdr_dout` in 64: downstream channel.
- `dropped_req` out 1: sticky flag, set when a `req` arrives while that port is already pending.

## Operation
- Per-port pending latch. A `req` pulse sets `pending` and captures addr; the CPU port also captures din and wr_sel. A `req` on a port that is already pending is ignored and sets `dropped_req`.
- FSM `ARB_IDLE → ARB_ISSUE → ARB_WAIT → ARB_IDLE`.
- IDLE: if any port is pending, grant by priority sprite > bg > cpu, latch the grant, go to ISSUE. If none is pending, stay.
- ISSUE: drive the granted port's addr/burst/din/wr_sel onto `sdr_*`, pulse `sdr_req` for exactly one cycle, go to WAIT.
- WAIT: hold all `sdr_*` fields stable. On `sdr_rdy`:
  - copy `sdr_dout` slice to the granted port's dout: sprite [63:0], bg [31:0], cpu [15:0];
  - pulse that port's `rdy` next cycle;
  - clear its pending;
  - go to IDLE.
- Port dout registers hold their value until that port's next completion.
- `sdr_wr_sel` is forced to 00 for sprite and bg grants.
- Simultaneous `req` and completion on the same port: completion clears pending, then the new req sets it. The new request is accepted, not dropped.
- `sdr_rdy` outside WAIT: ignored.
- Reset mid-transaction: all pending cleared, FSM to IDLE, any in-flight SDRAM result discarded. The SDRAM controller is reset by the same `reset`.

## Timing
- Reset values: all `rdy` 0, all dout 0, `sdr_req` 0, `sdr_addr` 0, `sdr_burst` 0, `sdr_din` 0, `sdr_wr_sel` 00, `dropped_req` 0, starve counter 0, FSM IDLE.
- `req` at cycle N: pending at N+1, grant decided at N+1, `sdr_req` high during N+2. Minimum latency is 2 cycles.
- `sdr_rdy` at cycle M: port `rdy` and updated dout at M+1. The FSM is in IDLE at M+1, so the next `sdr_req` can fire at M+2.
- Only one transaction is ever outstanding. There is no back-to-back `sdr_req`.

## Configuration
- `SDR_ARB_FAIRNESS_EN` defined:
  - a starve counter increments each time a grant goes elsewhere while the CPU is pending;
  - it resets to 0 on a CPU grant or when the CPU is not pending;
  - when it reaches `CPU_STARVE_LIMIT`, the CPU wins the next IDLE grant regardless of priority;
  - the counter is $clog2(CPU_STARVE_LIMIT+1) bits and saturates.
- Undefined: pure fixed priority; the counter logic is absent.

## Structure
- `m72_pkg` gains:
  - `arb_state_t` enum (ARB_IDLE, ARB_ISSUE, ARB_WAIT);
  - `sdr_port_t` enum (PORT_SPRITE, PORT_BG, PORT_CPU);
  - burst constants `BURST_1`=0, `BURST_2`=1, `BURST_4`=3.
- One sub-module, `sdr_arb_slot`, instantiated three times: pending latch, captured fields, dropped-request detect, `rdy` pulse generation.

## Test plan
- Single CPU read, addr 0x000100, `sdr_rdy` 3 cycles after `sdr_req`, `sdr_dout`=0x…BEEF → `sdr_req` at N+2 with burst 0, wr_sel 00; `cpu_rdy` one cycle after `sdr_rdy` with `cpu_dout`=0xBEEF.
- `spr_req`, `bg_req` and `cpu_req` in the same cycle → grants in order sprite (burst 3), bg (burst 1), cpu (burst 0); each `rdy` pulses exactly once.
- CPU write, `cpu_din`=0x1234, `cpu_wr_sel`=10 → `sdr_din`=0x1234 and `sdr_wr_sel`=10, held through WAIT.
- Fairness build, limit 4: CPU pending while sprite and bg re-request continuously → CPU granted on the 5th IDLE decision. Non-fairness build: CPU waits until both other ports are idle.
- Second `bg_req` while bg is pending → `dropped_req`=1 and only one bg transaction issued. `reset` asserted during WAIT → every output returns to its reset value and no `rdy` pulses.
